// File: rtl/cpu_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer: opcodes, ALU ops,
// write-back source selects and the sequencer state enum.
package cpu_pkg;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_LU = 7'b0110111;
  localparam logic [6:0] OP_AU = 7'b0010111;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_JL = 7'b1100111;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_L  = 7'b0000011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SRA = 4'b1101;

  localparam logic [2:0] RFWD_ALU   = 3'b000;
  localparam logic [2:0] RFWD_LOAD  = 3'b001;
  localparam logic [2:0] RFWD_LUI   = 3'b010;
  localparam logic [2:0] RFWD_AUIPC = 3'b011;
  localparam logic [2:0] RFWD_PC4   = 3'b100;

  typedef enum logic [3:0] {
    FETCH, DECODE, R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE,
    J_EXE, JL_EXE, S_EXE, S_MEM, L_EXE, L_MEM, L_WB
  } state_t;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_B, OP_LU, OP_AU, OP_J, OP_JL, OP_S, OP_L: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational ALU operation decode from {opcode, instr[30], funct3};
// usable unchanged by a single-cycle build.
module alu_decoder
  import cpu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic       instr30,
  input  logic [2:0] funct3,
  output logic [3:0] aluControl
);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    aluControl = ALU_ADD;
    case (opcode)
      OP_R, OP_B: aluControl = {instr30, funct3};
      // Immediate ops only honour bit 30 for SRAI; elsewhere it is immediate data.
      OP_I:       aluControl = ({instr30, funct3} == ALU_SRA) ? ALU_SRA : {1'b0, funct3};
      default:    aluControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I sequencer: steps each instruction through fetch, decode,
// execute, memory and write-back, and owns all architectural write enables.
module multicycle_control_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrCode,
  input  logic        busReady,
  output logic        pcEn,
  output logic        irWe,
  output logic        regFileWe,
  output logic        aluSrcMuxSel,
  output logic [3:0]  aluControl,
  output logic [2:0]  strb,
  output logic        busWe,
  output logic        busRe,
  output logic [2:0]  RFWDSrcMuxSel,
  output logic        branch,
  output logic        jal,
  output logic        jalr,
  output logic        illegalInstr
);

  state_t     state, state_next;
  logic [6:0] opcode;
  logic [3:0] decAluControl;
  logic       unused_instr_bits;

  assign opcode            = instrCode[6:0];
  assign unused_instr_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

  alu_decoder u_alu_decoder (
    .opcode    (opcode),
    .instr30   (instrCode[30]),
    .funct3    (instrCode[14:12]),
    .aluControl(decAluControl)
  );

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (opcode)
          OP_R:    state_next = R_EXE;
          OP_I:    state_next = I_EXE;
          OP_B:    state_next = B_EXE;
          OP_LU:   state_next = LU_EXE;
          OP_AU:   state_next = AU_EXE;
          OP_J:    state_next = J_EXE;
          OP_JL:   state_next = JL_EXE;
          OP_S:    state_next = S_EXE;
          OP_L:    state_next = L_EXE;
          default: state_next = FETCH;
        endcase
      end
      S_EXE:   state_next = S_MEM;
      S_MEM:   state_next = busReady ? FETCH : S_MEM;
      L_EXE:   state_next = L_MEM;
      L_MEM:   state_next = busReady ? L_WB : L_MEM;
      default: state_next = FETCH;
    endcase
  end

  // Everything is held at zero while reset is low, including the FETCH strobe.
  always_comb begin
    pcEn          = 1'b0;
    irWe          = 1'b0;
    regFileWe     = 1'b0;
    aluSrcMuxSel  = 1'b0;
    aluControl    = ALU_ADD;
    strb          = 3'b000;
    busWe         = 1'b0;
    busRe         = 1'b0;
    RFWDSrcMuxSel = RFWD_ALU;
    branch        = 1'b0;
    jal           = 1'b0;
    jalr          = 1'b0;
    illegalInstr  = 1'b0;
    if (reset) begin
      strb = instrCode[14:12];
      case (state)
        FETCH:  irWe = 1'b1;
        DECODE: begin
          illegalInstr = !is_legal_opcode(opcode);
          pcEn         = !is_legal_opcode(opcode);
        end
        R_EXE: begin
          regFileWe  = 1'b1;
          pcEn       = 1'b1;
          aluControl = decAluControl;
        end
        I_EXE: begin
          regFileWe    = 1'b1;
          pcEn         = 1'b1;
          aluSrcMuxSel = 1'b1;
          aluControl   = decAluControl;
        end
        B_EXE: begin
          branch     = 1'b1;
          pcEn       = 1'b1;
          aluControl = decAluControl;
        end
        LU_EXE: begin
          regFileWe     = 1'b1;
          pcEn          = 1'b1;
          RFWDSrcMuxSel = RFWD_LUI;
        end
        AU_EXE: begin
          regFileWe     = 1'b1;
          pcEn          = 1'b1;
          RFWDSrcMuxSel = RFWD_AUIPC;
        end
        J_EXE, JL_EXE: begin
          jal           = 1'b1;
          jalr          = (state == JL_EXE);
          regFileWe     = 1'b1;
          pcEn          = 1'b1;
          RFWDSrcMuxSel = RFWD_PC4;
        end
        S_EXE: aluSrcMuxSel = 1'b1;
        S_MEM: begin
          aluSrcMuxSel = 1'b1;
          busWe        = 1'b1;
          pcEn         = busReady;
        end
        L_EXE, L_MEM: begin
          aluSrcMuxSel  = 1'b1;
          RFWDSrcMuxSel = RFWD_LOAD;
          busRe         = (state == L_MEM);
        end
        L_WB: begin
          aluSrcMuxSel  = 1'b1;
          RFWDSrcMuxSel = RFWD_LOAD;
          regFileWe     = 1'b1;
          pcEn          = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
